ring_osc_freq_meter: RTL and testbench
======================================

// Module: ring_osc_freq_meter
// PURPOSE
//   Multi-channel frequency meter for the ring oscillator arrays. Enables up to N_CH rings at once
//   and counts their rising edges over a fixed gate window of fpga_clock cycles (the OSCH clock).
//   Latches one count per channel and serves the results through a registered read port.
//   Sits between the ring instances and the readout/UART logic.
// PARAMETERS
//   N_CH         4      number of ring channels measured in parallel (1..32)
//   CNT_W        16     width of each per-channel edge counter / result
//   GATE_CYCLES  1024   fpga_clock cycles in one counting window (>=1)
//   SETTLE_CYCLES 8     fpga_clock cycles rings run before counting starts (>=2, flushes syncs)
// PORTS
//   fpga_clock  in   1          measurement clock; all state on rising edge
//   reset       in   1          synchronous, active-high
//   start       in   1          1-cycle request; sampled only in IDLE
//   ch_mask     in   N_CH       channels to measure; captured with start
//   ring_in     in   N_CH       raw ring outputs, asynchronous to fpga_clock
//   ring_en     out  N_CH       enable to each ring (the ring's en input)
//   busy        out  1          high from accepted start until done
//   done        out  1          1-cycle pulse when results are valid
//   rd_sel      in   $clog2(N_CH) channel to read (min width 1)
//   rd_count    out  CNT_W      latched result of channel rd_sel, 1-cycle latency
//   ovf         out  N_CH       per-channel overflow flags of the last measurement
// BEHAVIOUR
//   - Reset: state=IDLE; ring_en=0, busy=0, done=0, rd_count=0, ovf=0, results and counters=0.
//   - Each ring_in passes a 2-flop synchroniser, then a 3rd flop for rising-edge detect.
//     Valid only when f_ring < fpga_clock/2; faster rings alias (documented limit, not checked).
//   - FSM IDLE -> SETTLE -> COUNT -> DONE -> IDLE:
//     IDLE:   start=1 -> latch ch_mask, ring_en<=ch_mask, busy<=1, timer=0, go SETTLE.
//             start with ch_mask==0 is accepted; it yields all-zero results and a done pulse.
//     SETTLE: ring_en held; after SETTLE_CYCLES cycles clear counters and ovf, go COUNT.
//     COUNT:  each masked channel increments on every detected rising edge; exactly
//             GATE_CYCLES cycles are counted (edges detected in those cycles only). Then go DONE.
//     DONE:   copy counters -> results, ovf stays; ring_en<=0, busy<=0, done=1 for this cycle only.
//   - Unmasked channels: ring_en=0, counter stays 0, result written as 0, ovf 0.
//   - start while busy is ignored (no queueing); start in the DONE cycle is also ignored.
//   - Counter wrap: without RO_SATURATE_EN, counts wrap modulo 2^CNT_W; ovf[i] set sticky on
//     the wrap and held until the next SETTLE.
//   - rd_count <= results[rd_sel] every cycle; rd_sel >= N_CH returns 0. Reading while busy
//     returns the previous measurement; results change only in the DONE cycle.
//   - reset mid-measurement: immediate return to IDLE, rings disabled, results cleared.
//   - Latency start->done = 1 + SETTLE_CYCLES + GATE_CYCLES cycles.
// CONFIGURATION
//   RO_SATURATE_EN defined: counters stop at 2^CNT_W-1 instead of wrapping; ovf[i] set on the
//     first edge arriving at the maximum value. Undefined: modulo wrap as above.
//     ovf is present in both builds.
// TESTING
//   1 reset: 3 cycles reset=1 -> ring_en=0, busy=0, done=0, rd_count=0, ovf=0.
//   2 ring0 driven at fpga_clock/8, GATE_CYCLES=1024, ch_mask=4'b0001, start -> done after
//     1033 cycles; rd_sel=0 gives 128 (+/-1); rd_sel=1..3 give 0.
//   3 four channels at /4, /6, /10, /20, mask=4'b1111 -> 256, 170/171, 102/103, 51/52 (+/-1).
//   4 CNT_W=4, ring at /4, GATE=128 (32 edges): wrap build gives 0 with ovf[0]=1;
//     RO_SATURATE_EN build gives 15 with ovf[0]=1.
//   5 start pulsed again during COUNT, and again in the DONE cycle -> ignored, single done pulse;
//     reset at COUNT cycle 500 -> IDLE next cycle, ring_en=0, rd_count=0.
//   6 ch_mask=0 start -> done after 1+SETTLE+GATE cycles, all results 0; rd_sel=N_CH -> 0.

Source files
------------

// File: rtl/ring_osc_freq_meter.sv
// Multi-channel ring oscillator frequency meter: counts synchronised rising edges per channel
// over a fixed gate window. Define RO_SATURATE_EN for saturating counters (default: modulo wrap).
module ring_osc_freq_meter #(
  parameter int unsigned  N_CH          = 4,
  parameter int unsigned  CNT_W         = 16,
  parameter int unsigned  GATE_CYCLES   = 1024,
  parameter int unsigned  SETTLE_CYCLES = 8,
  localparam int unsigned SEL_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_fpga_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [N_CH-1:0]  i_ch_mask,
  input  logic [N_CH-1:0]  i_ring_in,
  output logic [N_CH-1:0]  o_ring_en,
  output logic             o_busy,
  output logic             o_done,
  input  logic [SEL_W-1:0] i_rd_sel,
  output logic [CNT_W-1:0] o_rd_count,
  output logic [N_CH-1:0]  o_ovf
);

  localparam int unsigned      TMR_MAX     = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES
                                                                           : SETTLE_CYCLES;
  localparam int unsigned      TMR_W       = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StSettle, StCount, StDone} state_e;

  state_e                     r_state, w_state_next;
  logic [TMR_W-1:0]           r_timer;
  logic [N_CH-1:0]            r_sync1, r_sync2, r_sync3;
  logic [N_CH-1:0]            r_ring_en, r_ovf;
  logic [N_CH-1:0]            w_rise;
  logic [N_CH-1:0][CNT_W-1:0] r_cnt, r_results;
  logic [CNT_W-1:0]           r_rd_count;
  logic                       w_settle_last, w_gate_last;

  assign w_rise        = r_sync2 & ~r_sync3;
  assign w_settle_last = (r_timer == SETTLE_LAST);
  assign w_gate_last   = (r_timer == GATE_LAST);

  assign o_ring_en  = r_ring_en;
  assign o_busy     = (r_state != StIdle);
  assign o_done     = (r_state == StDone);
  assign o_rd_count = r_rd_count;
  assign o_ovf      = r_ovf;

  // Two flops of synchronisation plus one history flop for edge detection.
  always_ff @(posedge i_fpga_clock) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= i_ring_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge i_fpga_clock) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (i_start) w_state_next = StSettle;
      StSettle: if (w_settle_last) w_state_next = StCount;
      StCount:  if (w_gate_last) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Timer restarts on every state change so each phase counts from zero.
  always_ff @(posedge i_fpga_clock) begin
    if (i_reset || r_state == StIdle || w_state_next != r_state) r_timer <= '0;
    else                                                        r_timer <= r_timer + TMR_W'(1);
  end

  always_ff @(posedge i_fpga_clock) begin
    if (i_reset)                         r_ring_en <= '0;
    else if (r_state == StIdle && i_start) r_ring_en <= i_ch_mask;
    else if (r_state == StDone)          r_ring_en <= '0;
  end

  always_ff @(posedge i_fpga_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else if (r_state == StSettle && w_settle_last) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else if (r_state == StCount) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (r_ring_en[i] && w_rise[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_ovf[i] <= 1'b1;
`ifdef RO_SATURATE_EN
            r_cnt[i] <= CNT_MAX;
`else
            r_cnt[i] <= '0;
`endif
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge i_fpga_clock) begin
    if (i_reset)                r_results <= '0;
    else if (r_state == StDone) r_results <= r_cnt;
  end

  always_ff @(posedge i_fpga_clock) begin
    if (i_reset)                    r_rd_count <= '0;
    else if (32'(i_rd_sel) < N_CH)  r_rd_count <= r_results[i_rd_sel];
    else                            r_rd_count <= '0;
  end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Bench for ring_osc_freq_meter: default instance plus a narrow-counter 3-channel instance.
// Expected counts are queued when a measurement starts and popped as results are read back.
module tb_ring_osc_freq_meter;

  localparam int unsigned GATE_M   = 1024;
  localparam int unsigned GATE_S   = 128;
  localparam int unsigned SETTLE   = 8;

  logic        clk = 1'b0;
  logic        rst;

  logic        start_m, busy_m, done_m;
  logic [3:0]  mask_m, en_m, ovf_m;
  logic [3:0]  ring_m = '0;
  logic [1:0]  sel_m;
  logic [15:0] cnt_m;

  logic        start_s, busy_s, done_s;
  logic [2:0]  mask_s, en_s, ovf_s;
  logic [2:0]  ring_s = '0;
  logic [1:0]  sel_s;
  logic [3:0]  cnt_s;

  int half_m[4] = '{default: 0};
  int half_s[3] = '{default: 0};
  int pc_m[4]   = '{default: 0};
  int pc_s[3]   = '{default: 0};

  typedef struct {
    int unsigned val;
    int unsigned tol;
  } exp_t;
  exp_t sb_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  ring_osc_freq_meter u_dut (
    .i_fpga_clock (clk),
    .i_reset      (rst),
    .i_start      (start_m),
    .i_ch_mask    (mask_m),
    .i_ring_in    (ring_m),
    .o_ring_en    (en_m),
    .o_busy       (busy_m),
    .o_done       (done_m),
    .i_rd_sel     (sel_m),
    .o_rd_count   (cnt_m),
    .o_ovf        (ovf_m)
  );

  ring_osc_freq_meter #(
    .N_CH          (3),
    .CNT_W         (4),
    .GATE_CYCLES   (GATE_S),
    .SETTLE_CYCLES (SETTLE)
  ) u_small (
    .i_fpga_clock (clk),
    .i_reset      (rst),
    .i_start      (start_s),
    .i_ch_mask    (mask_s),
    .i_ring_in    (ring_s),
    .o_ring_en    (en_s),
    .o_busy       (busy_s),
    .o_done       (done_s),
    .i_rd_sel     (sel_s),
    .o_rd_count   (cnt_s),
    .o_ovf        (ovf_s)
  );

  always #5 clk = ~clk;

  // Ring models: square waves of period 2*half clocks, only running while enabled.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (en_m[i] && half_m[i] > 0) begin
        if (pc_m[i] == half_m[i] - 1) begin
          ring_m[i] = ~ring_m[i];
          pc_m[i]   = 0;
        end else begin
          pc_m[i]++;
        end
      end else begin
        ring_m[i] = 1'b0;
        pc_m[i]   = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (en_s[i] && half_s[i] > 0) begin
        if (pc_s[i] == half_s[i] - 1) begin
          ring_s[i] = ~ring_s[i];
          pc_s[i]   = 0;
        end else begin
          pc_s[i]++;
        end
      end else begin
        ring_s[i] = 1'b0;
        pc_s[i]   = 0;
      end
    end
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp,
                       input int unsigned tol);
    int unsigned diff;
    n_cmp++;
    diff = (obs > exp) ? obs - exp : exp - obs;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic push_exp(input int unsigned val, input int unsigned tol);
    exp_t e;
    e.val = val;
    e.tol = tol;
    sb_q.push_back(e);
  endtask

  // Expected edges over a gate for a ring of given half period on an enabled channel.
  task automatic push_ring(input int unsigned gate, input int hp, input bit on);
    int unsigned p;
    if (!on || hp == 0) begin
      push_exp(0, 0);
    end else begin
      p = 2 * hp;
      push_exp(gate / p, (gate % p) != 0 ? 1 : 0);
    end
  endtask

  task automatic read_check(input bit sm, input int unsigned sel, input string tag);
    exp_t e;
    @(negedge clk);
    if (sm) sel_s = 2'(sel);
    else    sel_m = 2'(sel);
    @(negedge clk);
    e = sb_q.pop_front();
    check(tag, sm ? 32'(cnt_s) : 32'(cnt_m), e.val, e.tol);
  endtask

  // Starts a measurement and times it to done; optional extra start pulses mid-run / on done.
  task automatic run_meas(input bit sm, input logic [3:0] mask, input int unsigned lat,
                          input int unsigned poke_at, input bit poke_done, input string tag);
    int unsigned cyc;
    bit          seen;
    @(negedge clk);
    if (sm) begin
      mask_s  = mask[2:0];
      start_s = 1'b1;
    end else begin
      mask_m  = mask;
      start_m = 1'b1;
    end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < lat + 50) begin
      @(negedge clk);
      cyc++;
      start_m = 1'b0;
      start_s = 1'b0;
      if (cyc == 1) begin
        check({tag, "_busy"}, sm ? 32'(busy_s) : 32'(busy_m), 1, 0);
        check({tag, "_en"}, sm ? 32'(en_s) : 32'(en_m), sm ? 32'(mask[2:0]) : 32'(mask), 0);
      end
      if (poke_at != 0 && cyc == poke_at) begin
        if (sm) start_s = 1'b1;
        else    start_m = 1'b1;
      end
      if (sm ? done_s : done_m) seen = 1'b1;
    end
    check({tag, "_lat"}, cyc, lat, 0);
    if (seen && poke_done) begin
      if (sm) start_s = 1'b1;
      else    start_m = 1'b1;
    end
    @(negedge clk);
    start_m = 1'b0;
    start_s = 1'b0;
    check({tag, "_pulse"}, sm ? 32'(done_s) : 32'(done_m), 0, 0);
    check({tag, "_idle"}, sm ? 32'(busy_s) : 32'(busy_m), 0, 0);
    check({tag, "_en_off"}, sm ? 32'(en_s) : 32'(en_m), 0, 0);
  endtask

  initial begin
    int unsigned extra_done;
    rst     = 1'b1;
    start_m = 1'b0;
    start_s = 1'b0;
    mask_m  = '0;
    mask_s  = '0;
    sel_m   = '0;
    sel_s   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_en", 32'(en_m), 0, 0);
    check("rst_busy", 32'(busy_m), 0, 0);
    check("rst_done", 32'(done_m), 0, 0);
    check("rst_cnt", 32'(cnt_m), 0, 0);
    check("rst_ovf", 32'(ovf_m), 0, 0);
    rst = 1'b0;

    // Single channel at clk/8
    half_m = '{4, 3, 5, 10};
    run_meas(1'b0, 4'b0001, 1 + SETTLE + GATE_M, 0, 1'b0, "one");
    push_ring(GATE_M, half_m[0], 1'b1);
    for (int i = 1; i < 4; i++) push_exp(0, 0);
    for (int i = 0; i < 4; i++) read_check(1'b0, i, $sformatf("one_ch%0d", i));
    check("one_ovf", 32'(ovf_m), 0, 0);

    // Four channels at /4, /6, /10, /20
    half_m = '{2, 3, 5, 10};
    run_meas(1'b0, 4'b1111, 1 + SETTLE + GATE_M, 0, 1'b0, "four");
    for (int i = 0; i < 4; i++) push_ring(GATE_M, half_m[i], 1'b1);
    for (int i = 0; i < 4; i++) read_check(1'b0, i, $sformatf("four_ch%0d", i));
    check("four_ovf", 32'(ovf_m), 0, 0);

    // 4-bit counters, 32 edges: wrap to 0 or saturate at 15, overflow flagged either way
    half_s = '{2, 3, 0};
    run_meas(1'b1, 4'b0001, 1 + SETTLE + GATE_S, 0, 1'b0, "narrow");
`ifdef RO_SATURATE_EN
    push_exp(15, 0);
`else
    push_exp(0, 0);
`endif
    push_exp(0, 0);
    push_exp(0, 0);
    read_check(1'b1, 0, "narrow_ch0");
    read_check(1'b1, 1, "narrow_ch1_masked");
    read_check(1'b1, 3, "narrow_sel_oob");
    check("narrow_ovf", 32'(ovf_s), 1, 0);

    // Extra starts during COUNT and in the DONE cycle are ignored
    half_m = '{4, 0, 0, 0};
    run_meas(1'b0, 4'b0001, 1 + SETTLE + GATE_M, 300, 1'b1, "ign");
    extra_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_m || busy_m) extra_done++;
    end
    check("ign_no_rerun", extra_done, 0, 0);
    push_ring(GATE_M, half_m[0], 1'b1);
    read_check(1'b0, 0, "ign_ch0");

    // Reset in the middle of COUNT
    @(negedge clk);
    mask_m  = 4'b1111;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (SETTLE + 500) @(negedge clk);
    check("mid_busy", 32'(busy_m), 1, 0);
    check("mid_rd_before", 32'(cnt_m), GATE_M / 8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_busy_rst", 32'(busy_m), 0, 0);
    check("mid_en_rst", 32'(en_m), 0, 0);
    check("mid_rd_rst", 32'(cnt_m), 0, 0);
    push_exp(0, 0);
    read_check(1'b0, 0, "mid_result_cleared");

    // Empty mask still completes with all-zero results
    half_m = '{2, 3, 5, 10};
    run_meas(1'b0, 4'b0000, 1 + SETTLE + GATE_M, 0, 1'b0, "empty");
    for (int i = 0; i < 4; i++) push_exp(0, 0);
    for (int i = 0; i < 4; i++) read_check(1'b0, i, $sformatf("empty_ch%0d", i));
    check("empty_ovf", 32'(ovf_m), 0, 0);

    check("sb_drain", sb_q.size(), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
